// File: rtl/mips_bus_arb_if.sv
// Fetch/data requester ports and the shared bus, bundled for mips_bus_arb.
// master is the arbiter's view; slave is the surrounding system's view.
interface mips_bus_arb_if;
  logic [31:0] IA;
  logic        IR;
  logic        IG;
  logic [31:0] IO;
  logic        IV;
  logic [31:0] DA;
  logic [3:0]  DW;
  logic [31:0] DD;
  logic        DR;
  logic        DG;
  logic [31:0] DI;
  logic        DV;
  logic [31:0] BA;
  logic [3:0]  BW;
  logic [31:0] BO;
  logic        BS;
  logic        BK;
  logic [31:0] BI;
  logic        busy;

  modport master (
    input  IA, IR, DA, DW, DD, DR, BK, BI,
    output IG, IO, IV, DG, DI, DV,
    output BA, BW, BO, BS, busy
  );

  modport slave (
    output IA, IR, DA, DW, DD, DR, BK, BI,
    input  IG, IO, IV, DG, DI, DV,
    input  BA, BW, BO, BS, busy
  );
endinterface

// File: rtl/mips_bus_arb.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding bus.
// Grants are combinational in IDLE; FAIR alternates under contention.
module mips_bus_arb #(
  parameter bit FAIR = 1'b1
) (
  input logic            clock,
  input logic            reset,
  mips_bus_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ba_q, ba_d;
  logic [3:0]  bw_q, bw_d;
  logic [31:0] bo_q, bo_d;
  logic [31:0] io_q, io_d;
  logic [31:0] di_q, di_d;
  logic        iv_q, iv_d;
  logic        dv_q, dv_d;
  logic        last_q, last_d;
  logic        ig, dg;
  logic        i_ok, d_ok;

  // A side stays ineligible through its own done-pulse cycle
  assign i_ok = bus.IR & ~iv_q;
  assign d_ok = (bus.DR | (|bus.DW)) & ~dv_q;

  always_comb begin
    state_d = state_q;
    ba_d    = ba_q;
    bw_d    = bw_q;
    bo_d    = bo_q;
    io_d    = io_q;
    di_d    = di_q;
    iv_d    = 1'b0;
    dv_d    = 1'b0;
    last_d  = last_q;
    ig      = 1'b0;
    dg      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!reset) begin
          if (i_ok && d_ok) begin
            ig = FAIR && last_q;
            dg = !ig;
          end else begin
            ig = i_ok;
            dg = d_ok;
          end
        end
        if (ig) begin
          state_d = FETCH;
          ba_d    = bus.IA;
          bw_d    = 4'd0;
          bo_d    = 32'd0;
          last_d  = 1'b0;
        end else if (dg) begin
          state_d = DATA;
          ba_d    = bus.DA;
          bw_d    = bus.DW;
          bo_d    = bus.DD;
          last_d  = 1'b1;
        end
      end
      FETCH: begin
        if (bus.BK) begin
          io_d    = bus.BI;
          iv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus.BK) begin
          if (bw_q == 4'd0) di_d = bus.BI;
          dv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ba_q    <= 32'd0;
      bw_q    <= 4'd0;
      bo_q    <= 32'd0;
      io_q    <= 32'd0;
      di_q    <= 32'd0;
      iv_q    <= 1'b0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ba_q    <= ba_d;
      bw_q    <= bw_d;
      bo_q    <= bo_d;
      io_q    <= io_d;
      di_q    <= di_d;
      iv_q    <= iv_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
    end
  end

  assign bus.IG   = ig;
  assign bus.DG   = dg;
  assign bus.IO   = io_q;
  assign bus.IV   = iv_q;
  assign bus.DI   = di_q;
  assign bus.DV   = dv_q;
  assign bus.BA   = ba_q;
  assign bus.BW   = bw_q;
  assign bus.BO   = bo_q;
  assign bus.BS   = (state_q != IDLE);
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_mips_bus_arb.sv
// Bench for mips_bus_arb: FAIR=1 and FAIR=0 instances share stimulus
// and are both checked every cycle against a transaction-level model.
module tb_mips_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ia, da, dd, bi;
  logic [3:0]  dw;
  logic        ir, dr, bk;

  always #5 clk = ~clk;

  mips_bus_arb_if bf1();
  mips_bus_arb_if bf0();

  assign bf1.IA = ia;
  assign bf1.IR = ir;
  assign bf1.DA = da;
  assign bf1.DW = dw;
  assign bf1.DD = dd;
  assign bf1.DR = dr;
  assign bf1.BK = bk;
  assign bf1.BI = bi;

  assign bf0.IA = ia;
  assign bf0.IR = ir;
  assign bf0.DA = da;
  assign bf0.DW = dw;
  assign bf0.DD = dd;
  assign bf0.DR = dr;
  assign bf0.BK = bk;
  assign bf0.BI = bi;

  mips_bus_arb #(.FAIR(1'b1)) dut1 (
    .clock(clk), .reset(rst), .bus(bf1)
  );
  mips_bus_arb #(.FAIR(1'b0)) dut0 (
    .clock(clk), .reset(rst), .bus(bf0)
  );

  typedef struct packed {
    logic        ig, dg, iv, dv, bs, busy;
    logic [31:0] io, di, ba, bo;
    logic [3:0]  bw;
  } out_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model: which transfer is on the bus (0 none, 1 fetch, 2 data),
  // which side is in its done cycle, and the last side granted.
  int          m_side[2];
  int          m_done[2];
  bit          m_last_data[2];
  logic [31:0] m_ba[2], m_bo[2], m_io[2], m_di[2];
  logic [3:0]  m_bw[2];

  out_t ob[2];

  function automatic out_t get_obs(int k);
    out_t o;
    if (k == 1)
      o = '{bf1.IG, bf1.DG, bf1.IV, bf1.DV, bf1.BS, bf1.busy,
            bf1.IO, bf1.DI, bf1.BA, bf1.BO, bf1.BW};
    else
      o = '{bf0.IG, bf0.DG, bf0.IV, bf0.DV, bf0.BS, bf0.busy,
            bf0.IO, bf0.DI, bf0.BA, bf0.BO, bf0.BW};
    return o;
  endfunction

  function automatic out_t model_out(int k);
    out_t e;
    bit   f_want, d_want;
    e      = '0;
    e.bs   = (m_side[k] != 0);
    e.busy = e.bs;
    e.iv   = (m_done[k] == 1);
    e.dv   = (m_done[k] == 2);
    e.io   = m_io[k];
    e.di   = m_di[k];
    e.ba   = m_ba[k];
    e.bw   = m_bw[k];
    e.bo   = m_bo[k];
    f_want = ir && (m_done[k] != 1);
    d_want = (dr || dw != 4'd0) && (m_done[k] != 2);
    if (m_side[k] == 0 && !rst) begin
      if (f_want && d_want) begin
        // k==1 is the fair instance
        if (k == 1 && m_last_data[k]) e.ig = 1'b1;
        else e.dg = 1'b1;
      end else begin
        e.ig = f_want;
        e.dg = d_want;
      end
    end
    return e;
  endfunction

  task automatic model_reset(int k);
    m_side[k]      = 0;
    m_done[k]      = 0;
    m_last_data[k] = 1'b0;
    m_ba[k]        = '0;
    m_bw[k]        = '0;
    m_bo[k]        = '0;
    m_io[k]        = '0;
    m_di[k]        = '0;
  endtask

  task automatic model_tick();
    out_t e;
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      if (rst) begin
        model_reset(k);
      end else begin
        m_done[k] = 0;
        if (m_side[k] != 0) begin
          if (bk) begin
            if (m_side[k] == 1) m_io[k] = bi;
            else if (m_bw[k] == 4'd0) m_di[k] = bi;
            m_done[k] = m_side[k];
            m_side[k] = 0;
          end
        end else if (e.ig) begin
          m_side[k] = 1;
          m_ba[k] = ia;
          m_bw[k] = 4'd0;
          m_bo[k] = 32'd0;
          m_last_data[k] = 1'b0;
        end else if (e.dg) begin
          m_side[k] = 2;
          m_ba[k] = da;
          m_bw[k] = dw;
          m_bo[k] = dd;
          m_last_data[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic settle();
    out_t  e;
    string p;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      p = (k == 1) ? "fair1" : "fair0";
      ob[k] = get_obs(k);
      e = model_out(k);
      chk({p, ".IG"}, ob[k].ig, e.ig);
      chk({p, ".DG"}, ob[k].dg, e.dg);
      chk({p, ".IV"}, ob[k].iv, e.iv);
      chk({p, ".DV"}, ob[k].dv, e.dv);
      chk({p, ".BS"}, ob[k].bs, e.bs);
      chk({p, ".busy"}, ob[k].busy, e.busy);
      chk({p, ".IO"}, ob[k].io, e.io);
      chk({p, ".DI"}, ob[k].di, e.di);
      chk({p, ".BA"}, ob[k].ba, e.ba);
      chk({p, ".BW"}, ob[k].bw, e.bw);
      chk({p, ".BO"}, ob[k].bo, e.bo);
      chk({p, ".grant_excl"}, ob[k].ig & ob[k].dg, 0);
      chk({p, ".done_excl"}, ob[k].iv & ob[k].dv, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle_in();
    ir = 0; ia = '0; dr = 0; dw = '0;
    da = '0; dd = '0; bk = 0; bi = '0;
  endtask

  int gq1[$], gq0[$];
  int dv_cnt;

  initial begin
    idle_in();
    rst = 1;
    for (int k = 0; k < 2; k++) model_reset(k);
    @(posedge clk);
    model_tick();
    #1;
    cyc();
    rst = 0;

    // Reset state
    settle();
    chk("rst_BS", ob[1].bs, 0);
    chk("rst_busy", ob[1].busy, 0);
    chk("rst_IO", ob[1].io, 0);
    chk("rst_DI", ob[1].di, 0);
    tick();

    // Minimum-latency fetch
    ir = 1; ia = 32'h0040_0000;
    settle();
    chk("fetch_IG_c0", ob[1].ig, 1);
    tick();
    bk = 1; bi = 32'h2408_0005;
    settle();
    chk("fetch_BS_c1", ob[1].bs, 1);
    chk("fetch_BA_c1", ob[1].ba, 32'h0040_0000);
    tick();
    ir = 0; bk = 0; bi = '0;
    settle();
    chk("fetch_IV_c2", ob[1].iv, 1);
    chk("fetch_IO_c2", ob[1].io, 32'h2408_0005);
    tick();

    // Data read to seed DI
    dr = 1; da = 32'h2000;
    cyc();
    dr = 0; bk = 1; bi = 32'h5A5A_1234;
    cyc();
    bk = 0;
    settle();
    chk("dread_DI", ob[1].di, 32'h5A5A_1234);
    tick();

    // Data write with BK delayed three cycles
    dw = 4'b0011; da = 32'h1000; dd = 32'h0000_BEEF;
    settle();
    chk("dwr_DG", ob[1].dg, 1);
    tick();
    dw = '0; da = '0; dd = '0; bi = 32'hFFFF_FFFF;
    dv_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("dwr_hold_BS", ob[1].bs, 1);
      chk("dwr_hold_BA", ob[1].ba, 32'h1000);
      chk("dwr_hold_BW", ob[1].bw, 4'b0011);
      chk("dwr_hold_BO", ob[1].bo, 32'h0000_BEEF);
      tick();
    end
    bk = 1;
    cyc();
    bk = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      if (ob[1].dv) dv_cnt++;
      if (c == 0) chk("dwr_DI_kept", ob[1].di, 32'h5A5A_1234);
      tick();
    end
    chk("dwr_DV_once", dv_cnt, 1);

    // Contention right after a data grant: fair picks fetch
    dw = 4'b1000; da = 32'h30;
    cyc();
    dw = '0; bk = 1;
    cyc();
    bk = 0;
    cyc();
    ir = 1; dr = 1;
    settle();
    chk("fair1_after_data", ob[1].ig, 1);
    chk("fair0_after_data", ob[0].dg, 1);
    tick();
    idle_in();
    bk = 1;
    cyc();
    bk = 0;
    cyc();

    // Reset in the middle of a data transfer
    dr = 1; da = 32'h44;
    cyc();
    dr = 0; rst = 1;
    settle();
    chk("rstmid_BS_before", ob[1].bs, 1);
    tick();
    rst = 0; ir = 1; dr = 1;
    settle();
    chk("rstmid_BS", ob[1].bs, 0);
    chk("rstmid_DV", ob[1].dv, 0);
    chk("rstmid_last_fetch", ob[1].dg, 1);
    tick();
    idle_in();
    bk = 1;
    cyc();
    bk = 0;
    cyc();

    // Continuous contention: grant order
    rst = 1;
    cyc();
    rst = 0;
    ir = 1; dr = 1; bk = 1; bi = 32'h77;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (ob[1].ig) gq1.push_back(1);
      if (ob[1].dg) gq1.push_back(2);
      if (ob[0].ig) gq0.push_back(1);
      if (ob[0].dg) gq0.push_back(2);
      tick();
    end
    chk("order_len1", gq1.size(), 6);
    chk("order_len0", gq0.size(), 6);
    for (int i = 0; i < 4; i++) begin
      chk("order_fair1", gq1[i], (i % 2 == 0) ? 2 : 1);
      chk("order_fair0", gq0[i], (i % 2 == 0) ? 2 : 1);
    end
    idle_in();
    bk = 1;
    for (int c = 0; c < 3; c++) cyc();

    // BK while idle with no request
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("idle_bk_busy", ob[1].busy, 0);
      chk("idle_bk_IV", ob[1].iv, 0);
      chk("idle_bk_DV", ob[1].dv, 0);
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      ir  = $urandom_range(0, 1) == 1;
      dr  = $urandom_range(0, 1) == 1;
      dw  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      ia  = $urandom;
      da  = $urandom;
      dd  = $urandom;
      bk  = $urandom_range(0, 1) == 1;
      bi  = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_bus_arb.md
MIPS_BUS_ARB -- requirements
Module: mips_bus_arb

Interface
REQ-001 Parameter: FAIR, default 1, alternates grants when both requesters contend; 0 gives data strict priority.
REQ-002 clock  in  1  single clock; all state changes on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 IA  in  32  fetch word address.
REQ-005 IR  in  1  fetch request (level).
REQ-006 IG  out  1  fetch grant, combinational, one cycle.
REQ-007 IO  out  32  fetched word.
REQ-008 IV  out  1  fetch done pulse.
REQ-009 DA  in  32  data address.
REQ-010 DW  in  4  data byte write enables.
REQ-011 DD  in  32  data write value.
REQ-012 DR  in  1  data read request.
REQ-013 DG  out  1  data grant, combinational, one cycle.
REQ-014 DI  out  32  data read value.
REQ-015 DV  out  1  data done pulse.
REQ-016 BA  out  32  bus address.
REQ-017 BW  out  4  bus byte write enables.
REQ-018 BO  out  32  bus write data.
REQ-019 BS  out  1  bus strobe.
REQ-020 BK  in  1  bus acknowledge.
REQ-021 BI  in  32  bus read data, valid with BK.
REQ-022 busy  out  1  high while state is not IDLE.

Function
REQ-023 The block SHALL have states IDLE, FETCH and DATA, with a single outstanding bus transfer.
REQ-024 A data request SHALL be DR=1 or DW!=0; when DW!=0 it SHALL be a write regardless of DR.
REQ-025 A requester SHALL be ineligible from its grant cycle through its done-pulse cycle inclusive, and eligible again from the following cycle.
REQ-026 In IDLE with exactly one eligible request, that side SHALL be granted (IG or DG high) in the same cycle.
REQ-027 With both eligible in IDLE: if FAIR=0, data SHALL win; if FAIR=1, data SHALL win unless the last grant was data, in which case fetch SHALL win.
REQ-028 On the grant edge, the block SHALL latch address, BW (DW for data, 0 for fetch) and BO (DD for data, 0 for fetch), and SHALL enter FETCH or DATA.
REQ-029 In FETCH or DATA, BS SHALL be 1 and BA/BW/BO SHALL be held constant until BK=1 is sampled.
REQ-030 BK SHALL be ignored while BS=0.
REQ-031 On the BK edge, the block SHALL set IO<=BI (fetch) or DI<=BI (data read), leave DI unchanged on data write, and pulse IV or DV for exactly the next cycle.
REQ-032 On the BK edge, the block SHALL return to IDLE; BS SHALL be 0 in the done cycle and a new grant to the other, eligible side MAY occur in that same cycle.
REQ-033 Minimum latency SHALL be: request at cycle g -> BS at g+1 -> with BK at g+1, done pulse at g+2.
REQ-034 IO and DI SHALL hold their values between completions.
REQ-035 IG and DG SHALL never be high together; IV and DV SHALL never be high together.

Reset
REQ-036 Reset SHALL force IDLE, BS=0, BA=0, BW=0, BO=0, IV=DV=0, IO=DI=0, busy=0 and last-grant=fetch.
REQ-037 Reset during FETCH or DATA SHALL abandon the transfer: BS=0 on the next cycle and no done pulse.
REQ-038 The block SHALL make no grant in a cycle where reset=1.

Verification
REQ-039 IR=1, IA=0x00400000; BK=1 on the first BS cycle with BI=0x24080005 -> IG at cycle 0, BS at cycle 1, IV=1 and IO=0x24080005 at cycle 2.
REQ-040 DW=4'b0011, DA=0x1000, DD=0xBEEF; BK delayed 3 cycles -> BS=1, BA=0x1000, BW=3 and BO=0xBEEF held for 3 cycles; DV pulses once; DI unchanged.
REQ-041 FAIR=1 with IR=1 and DR=1 held continuously -> grant order is data, fetch, data, fetch; FAIR=0 -> data, fetch, data only after each done cycle (data first whenever eligible).
REQ-042 Reset asserted for 1 cycle while BS=1 during DATA -> BS=0 the next cycle, no DV, IDLE, last-grant=fetch.
REQ-043 BK=1 while IDLE with no request -> no state change, no done pulse.
